// File: rtl/memory_stage_pkg.sv
// Shared definitions for the MEM stage: default widths, FSM state type and
// a helper for sizing the access timeout counter.
package memory_stage_pkg;

  localparam int unsigned PC_WIDTH_DEF       = 20;
  localparam int unsigned DATA_WIDTH_DEF     = 32;
  localparam int unsigned REG_ADDR_WIDTH_DEF = 5;
  localparam int unsigned MEM_ADDR_WIDTH_DEF = 20;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 15;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } mem_state_e;

  // Counter only needs to hold 0 .. n-1.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/memory_stage_if.sv
// Data memory req/ack bus. The MEM stage is the master; the memory is the slave.
interface memory_stage_if #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned MEM_ADDR_WIDTH = 20
);
  logic                      dmem_req;
  logic                      dmem_we;
  logic [MEM_ADDR_WIDTH-1:0] dmem_addr;
  logic [DATA_WIDTH-1:0]     dmem_wdata;
  logic [DATA_WIDTH-1:0]     dmem_rdata;
  logic                      dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/memory_stage_pipe.sv
// MEM/WB pipeline register: bubble clears every field, enable captures.
module memory_pipe #(
  parameter int unsigned PC_WIDTH       = 20,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      bubble,
  input  logic [DATA_WIDTH-1:0]     mem_data_d,
  input  logic [DATA_WIDTH-1:0]     alu_data_d,
  input  logic                      reg_wr_en_d,
  input  logic [REG_ADDR_WIDTH-1:0] reg_wr_addr_d,
  input  logic                      write_back_mux_sel_d,
  input  logic                      select_new_pc_d,
  input  logic [PC_WIDTH-1:0]       new_pc_d,
  output logic [DATA_WIDTH-1:0]     mem_data_q,
  output logic [DATA_WIDTH-1:0]     alu_data_q,
  output logic                      reg_wr_en_q,
  output logic [REG_ADDR_WIDTH-1:0] reg_wr_addr_q,
  output logic                      write_back_mux_sel_q,
  output logic                      select_new_pc_q,
  output logic [PC_WIDTH-1:0]       new_pc_q
);

  // Register the MEM/WB payload; a bubble has precedence over capture.
  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      mem_data_q           <= '0;
      alu_data_q           <= '0;
      reg_wr_en_q          <= 1'b0;
      reg_wr_addr_q        <= '0;
      write_back_mux_sel_q <= 1'b0;
      select_new_pc_q      <= 1'b0;
      new_pc_q             <= '0;
    end else if (en) begin
      mem_data_q           <= mem_data_d;
      alu_data_q           <= alu_data_d;
      reg_wr_en_q          <= reg_wr_en_d;
      reg_wr_addr_q        <= reg_wr_addr_d;
      write_back_mux_sel_q <= write_back_mux_sel_d;
      select_new_pc_q      <= select_new_pc_d;
      new_pc_q             <= new_pc_d;
    end
  end

endmodule

// File: rtl/memory_stage.sv
// MEM stage: issues loads/stores on the dmem bus, stalls upstream while an
// access is outstanding, aborts on timeout and feeds the MEM/WB register.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int unsigned PC_WIDTH       = PC_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int unsigned REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
  parameter int unsigned MEM_ADDR_WIDTH = MEM_ADDR_WIDTH_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mem_data_rd_en_in,
  input  logic                      mem_data_wr_en_in,
  input  logic [DATA_WIDTH-1:0]     mem_data_in,
  input  logic [DATA_WIDTH-1:0]     alu_data_in,
  input  logic                      reg_wr_en_in,
  input  logic [REG_ADDR_WIDTH-1:0] reg_wr_addr_in,
  input  logic                      write_back_mux_sel_in,
  input  logic                      select_new_pc_in,
  input  logic [PC_WIDTH-1:0]       new_pc_in,
  memory_stage_if.master            dmem,
  output logic                      stall_out,
  output logic [DATA_WIDTH-1:0]     mem_data_out,
  output logic [DATA_WIDTH-1:0]     alu_data_out,
  output logic                      reg_wr_en_out,
  output logic [REG_ADDR_WIDTH-1:0] reg_wr_addr_out,
  output logic                      write_back_mux_sel_out,
  output logic                      select_new_pc_out,
  output logic [PC_WIDTH-1:0]       new_pc_out,
  output logic                      bus_error_out
);

  localparam int unsigned CNT_W = cnt_width(TIMEOUT_CYCLES);

  mem_state_e                state;
  logic [CNT_W-1:0]          cnt;
  logic                      req_q;
  logic                      we_q;
  logic [MEM_ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]     wdata_q;
  logic                      mem_op;
  logic                      timeout_now;
  logic                      is_load_q;
  logic [DATA_WIDTH-1:0]     mem_data_d;
  logic                      reg_wr_en_d;

  assign mem_op      = mem_data_rd_en_in | mem_data_wr_en_in;
  assign is_load_q   = ~we_q;
  assign timeout_now = (state == ST_ACCESS) && !dmem.dmem_ack &&
                       (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;

  // Stall while launching or waiting; a timed-out access also releases
  // upstream, otherwise the aborted instruction would be re-issued.
  always_comb begin
    stall_out = 1'b0;
    if (state == ST_IDLE) stall_out = mem_op;
    else                  stall_out = !(dmem.dmem_ack || timeout_now);
  end

  // Commit payload: load data only on a real ack; aborted loads never write back.
  always_comb begin
    mem_data_d  = '0;
    reg_wr_en_d = reg_wr_en_in;
    if (state == ST_ACCESS) begin
      if (dmem.dmem_ack && is_load_q) mem_data_d = dmem.dmem_rdata;
      if (timeout_now && is_load_q)   reg_wr_en_d = 1'b0;
    end
  end

  // Access FSM, timeout counter, dmem request registers and error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      req_q         <= 1'b0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      bus_error_out <= 1'b0;
    end else begin
      bus_error_out <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (mem_op) begin
            req_q         <= 1'b1;
            we_q          <= mem_data_wr_en_in;
            addr_q        <= alu_data_in[MEM_ADDR_WIDTH-1:0];
            wdata_q       <= mem_data_in;
            bus_error_out <= mem_data_rd_en_in & mem_data_wr_en_in;
            cnt           <= '0;
            state         <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (dmem.dmem_ack) begin
            req_q <= 1'b0;
            cnt   <= '0;
            state <= ST_IDLE;
          end else if (timeout_now) begin
            req_q         <= 1'b0;
            bus_error_out <= 1'b1;
            cnt           <= '0;
            state         <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  memory_pipe #(
    .PC_WIDTH       (PC_WIDTH),
    .DATA_WIDTH     (DATA_WIDTH),
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_pipe (
    .clk                  (clk),
    .rst                  (rst),
    .en                   (!stall_out),
    .bubble               (stall_out),
    .mem_data_d           (mem_data_d),
    .alu_data_d           (alu_data_in),
    .reg_wr_en_d          (reg_wr_en_d),
    .reg_wr_addr_d        (reg_wr_addr_in),
    .write_back_mux_sel_d (write_back_mux_sel_in),
    .select_new_pc_d      (select_new_pc_in),
    .new_pc_d             (new_pc_in),
    .mem_data_q           (mem_data_out),
    .alu_data_q           (alu_data_out),
    .reg_wr_en_q          (reg_wr_en_out),
    .reg_wr_addr_q        (reg_wr_addr_out),
    .write_back_mux_sel_q (write_back_mux_sel_out),
    .select_new_pc_q      (select_new_pc_out),
    .new_pc_q             (new_pc_out)
  );

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: directed cases plus random instruction stream,
// each instruction checked against a transaction-level expectation.
module tb_memory_stage;

  localparam int PCW = 20;
  localparam int DW  = 32;
  localparam int RAW = 5;
  localparam int MAW = 20;
  localparam int TO  = 15;

  logic           clk = 1'b0;
  logic           rst;
  logic           rd_in, wr_in, rwe_in, wbsel_in, snp_in;
  logic [DW-1:0]  wd_in, alu_in;
  logic [RAW-1:0] rwa_in;
  logic [PCW-1:0] npc_in;
  logic           stall_out, reg_wr_en_out, wbsel_out, snp_out, bus_error_out;
  logic [DW-1:0]  mem_data_out, alu_data_out;
  logic [RAW-1:0] reg_wr_addr_out;
  logic [PCW-1:0] new_pc_out;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  memory_stage_if #(.DATA_WIDTH(DW), .MEM_ADDR_WIDTH(MAW)) dif ();

  memory_stage #(
    .PC_WIDTH(PCW), .DATA_WIDTH(DW), .REG_ADDR_WIDTH(RAW),
    .MEM_ADDR_WIDTH(MAW), .TIMEOUT_CYCLES(TO)
  ) u_dut (
    .clk                    (clk),
    .rst                    (rst),
    .mem_data_rd_en_in      (rd_in),
    .mem_data_wr_en_in      (wr_in),
    .mem_data_in            (wd_in),
    .alu_data_in            (alu_in),
    .reg_wr_en_in           (rwe_in),
    .reg_wr_addr_in         (rwa_in),
    .write_back_mux_sel_in  (wbsel_in),
    .select_new_pc_in       (snp_in),
    .new_pc_in              (npc_in),
    .dmem                   (dif),
    .stall_out              (stall_out),
    .mem_data_out           (mem_data_out),
    .alu_data_out           (alu_data_out),
    .reg_wr_en_out          (reg_wr_en_out),
    .reg_wr_addr_out        (reg_wr_addr_out),
    .write_back_mux_sel_out (wbsel_out),
    .select_new_pc_out      (snp_out),
    .new_pc_out             (new_pc_out),
    .bus_error_out          (bus_error_out)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drive_idle();
    rd_in = 0; wr_in = 0; wd_in = '0; alu_in = '0; rwe_in = 0;
    rwa_in = '0; wbsel_in = 0; snp_in = 0; npc_in = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_data"}, mem_data_out, 0);
    check({tag, "_alu_data"}, alu_data_out, 0);
    check({tag, "_wr_en"}, reg_wr_en_out, 0);
    check({tag, "_wr_addr"}, reg_wr_addr_out, 0);
    check({tag, "_wbsel"}, wbsel_out, 0);
    check({tag, "_new_pc_sel"}, snp_out, 0);
    check({tag, "_new_pc"}, new_pc_out, 0);
    check({tag, "_bus_err"}, bus_error_out, 0);
    check({tag, "_req"}, dif.dmem_req, 0);
    check({tag, "_we"}, dif.dmem_we, 0);
    check({tag, "_addr"}, dif.dmem_addr, 0);
  endtask

  // One instruction held at the stage input until it leaves. ack_at is the
  // ACCESS cycle (1-based) in which memory acks; 0 or >TO means never.
  // Called 1 time unit after a rising edge.
  task automatic run_instr(input logic rd, input logic wr, input logic [DW-1:0] wd,
                           input logic [DW-1:0] alu, input logic rwe, input logic [RAW-1:0] rwa,
                           input logic wbsel, input logic snp, input logic [PCW-1:0] npc,
                           input int ack_at, input logic [DW-1:0] rdata);
    bit is_mem, is_load, acked, done, st, ack;
    int exp_stalls, exp_errs, stalls, reqs, errs, acc;
    logic [MAW-1:0] exp_addr;
    rd_in = rd; wr_in = wr; wd_in = wd; alu_in = alu; rwe_in = rwe;
    rwa_in = rwa; wbsel_in = wbsel; snp_in = snp; npc_in = npc;
    exp_addr   = alu[MAW-1:0];
    is_mem     = rd | wr;
    is_load    = rd & !wr;
    acked      = is_mem && ack_at >= 1 && ack_at <= TO;
    exp_stalls = !is_mem ? 0 : (acked ? ack_at : TO);
    exp_errs   = int'(rd && wr) + int'(is_mem && !acked);
    stalls = 0; reqs = 0; errs = 0; acc = 0; done = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      ack = 0;
      if (dif.dmem_req) begin
        acc++;
        ack = (acc == ack_at);
      end
      dif.dmem_ack   = ack;
      dif.dmem_rdata = ack ? rdata : DW'($urandom);
      #1;
      if (dif.dmem_req) begin
        reqs++;
        check("dmem_addr", dif.dmem_addr, exp_addr);
        check("dmem_we", dif.dmem_we, wr);
        check("dmem_wdata", dif.dmem_wdata, wd);
      end
      st = stall_out;
      if (st) stalls++;
      @(posedge clk); #1;
      dif.dmem_ack = 0;
      errs += int'(bus_error_out);
      if (!st) begin
        done = 1;
        break;
      end
      check("bubble_wr_en", reg_wr_en_out, 0);
      check("bubble_new_pc_sel", snp_out, 0);
    end
    if (!done) check("commit_within_bound", 0, 1);
    check("stall_cycles", stalls, exp_stalls);
    check("req_cycles", reqs, exp_stalls);
    check("bus_error_pulses", errs, exp_errs);
    check("req_dropped", dif.dmem_req, 0);
    check("alu_data_out", alu_data_out, alu);
    check("mem_data_out", mem_data_out, (acked && is_load) ? rdata : '0);
    check("reg_wr_en_out", reg_wr_en_out, rwe && !(is_load && !acked));
    check("reg_wr_addr_out", reg_wr_addr_out, rwa);
    check("wbsel_out", wbsel_out, wbsel);
    check("new_pc_sel_out", snp_out, snp);
    check("new_pc_out", new_pc_out, npc);
  endtask

  initial begin
    rst = 1;
    drive_idle();
    dif.dmem_ack = 0;
    dif.dmem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    check("reset_stall", stall_out, 0);
    rst = 0;

    // ALU op, load with 3 wait cycles, store with zero wait
    run_instr(0, 0, 32'h0, 32'h1234, 1, 5'd3, 0, 0, '0, 0, '0);
    run_instr(1, 0, 32'h0, 32'h40, 1, 5'd7, 1, 0, '0, 4, 32'hDEADBEEF);
    run_instr(0, 1, 32'hA5A5A5A5, 32'h10, 0, 5'd0, 0, 0, '0, 1, '0);
    // timeout, ack exactly on the last allowed cycle, rd&wr together
    run_instr(1, 0, 32'h0, 32'h80, 1, 5'd9, 1, 0, '0, 0, '0);
    run_instr(1, 0, 32'h0, 32'h84, 1, 5'd10, 1, 0, '0, TO, 32'h0BADF00D);
    run_instr(1, 1, 32'h55AA55AA, 32'h20, 0, 5'd0, 0, 1, 20'hABCDE, 2, 32'h12345678);
    // back-to-back zero-wait loads
    for (int i = 0; i < 4; i++)
      run_instr(1, 0, 32'h0, 32'h100 + i, 1, RAW'(i + 1), 1, 0, '0, 1, 32'hC0DE0000 + i);

    // reset during the 2nd ACCESS cycle, late ack afterwards
    rd_in = 1; alu_in = 32'h44; rwe_in = 1; rwa_in = 5'd4; wbsel_in = 1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    check("pre_reset_req", dif.dmem_req, 1);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    drive_idle();
    dif.dmem_ack = 1;
    dif.dmem_rdata = 32'hFFFFFFFF;
    #1;
    check("late_ack_stall", stall_out, 0);
    @(posedge clk); #1;
    dif.dmem_ack = 0;
    check_all_zero("late_ack");
    run_instr(0, 0, 32'h0, 32'h777, 1, 5'd12, 0, 1, 20'h00042, 0, '0);

    // random instruction stream
    for (int n = 0; n < 80; n++) begin
      int op, ack_at;
      op = $urandom_range(0, 9);
      ack_at = ($urandom_range(0, 7) == 0) ? $urandom_range(0, TO + 2) : $urandom_range(1, 4);
      run_instr(op inside {[4:6], 9}, op inside {[7:9]}, $urandom, $urandom,
                1'($urandom), RAW'($urandom), 1'($urandom), 1'($urandom),
                PCW'($urandom), ack_at, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: got timeout expected finish");
    $fatal(1);
  end

endmodule
